// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared register map, CTRL/STATUS field positions and hex-to-segment table
// Contents: register address localparams, CTRL and STATUS bit positions, hex7() decoder.
package seg7_pkg;

  localparam logic [1:0] ADDR_DIGITS = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_BLANK_LSB   = 8;
  localparam int CTRL_DP_LSB      = 16;
  localparam int STATUS_FRAME_BIT = 8;
  localparam int STATUS_BLINK_BIT = 9;

  // Active-high segments, bit0 = a ... bit6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// rtl/seg7_scan_timer.sv - digit-slot prescaler, digit index, frame toggle and dead-time qualifier
// Ports: clk, reset_n (async, active low), enable (low holds everything at 0);
//   index / slot_active: digit index and "past dead time" flag the timer will hold after the
//   coming edge, so registered outputs built from them line up with the prescaler;
//   frame_wrap: high in the cycle whose edge wraps the last digit back to 0;
//   cur_index / frame: current registered index and frame toggle for status readback.
module seg7_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEADTIME   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [2:0] index,
  output logic       slot_active,
  output logic       frame_wrap,
  output logic [2:0] cur_index,
  output logic       frame
);

  localparam int            PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_DEAD = PW'(DEADTIME);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_q, frame_d;
  logic          wrap;

  always_comb begin
    pre_d   = '0;
    idx_d   = '0;
    frame_d = 1'b0;
    wrap    = 1'b0;
    if (enable) begin
      pre_d   = pre_q + 1'b1;
      idx_d   = idx_q;
      frame_d = frame_q;
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          frame_d = ~frame_q;
          wrap    = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

  assign index       = idx_d;
  assign slot_active = (pre_d >= PRE_DEAD);
  assign frame_wrap  = wrap;
  assign cur_index   = idx_q;
  assign frame       = frame_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - Avalon-MM multiplexed seven-segment display controller
// Ports: clk, reset_n (async, active low); Avalon slave address/chipselect/write_n/writedata,
//   readdata (combinational); seg_n (active-low segments, bit7 = dp); dig_n (active-low digit select).
// Optional feature macro: SEG7_BLINK_EN (BLINK register, blink phase counter).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEADTIME     = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  logic                    wr_en;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic                    enable_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    blink_phase_q;
  logic                    blink_phase_d;
  logic                    unused_bits;

  logic [2:0] scan_index;
  logic       slot_active;
  logic       frame_wrap;
  logic [2:0] cur_index;
  logic       frame;

  assign wr_en = chipselect && !write_n;

  seg7_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .DEADTIME  (DEADTIME)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable_q),
    .index      (scan_index),
    .slot_active(slot_active),
    .frame_wrap (frame_wrap),
    .cur_index  (cur_index),
    .frame      (frame)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= '0;
      enable_q <= 1'b1;
      blank_q  <= '0;
      dp_q     <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_DIGITS: digits_q <= writedata[4*NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          enable_q <= writedata[CTRL_ENABLE_BIT];
          blank_q  <= writedata[CTRL_BLANK_LSB +: NUM_DIGITS];
          dp_q     <= writedata[CTRL_DP_LSB +: NUM_DIGITS];
        end
        default: ;
      endcase
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt_q;

  // Phase is computed one edge ahead so the segment value registered on the
  // frame-wrap edge already reflects the new phase.
  assign blink_phase_d = blink_phase_q ^ (frame_wrap && (blink_cnt_q == BLINK_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_BLINK)) begin
        blink_q <= writedata[NUM_DIGITS-1:0];
      end
      if (frame_wrap) begin
        blink_cnt_q <= (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
      end
      blink_phase_q <= blink_phase_d;
    end
  end

  assign unused_bits = ^writedata;
`else
  assign blink_q       = '0;
  assign blink_phase_q = 1'b0;
  assign blink_phase_d = 1'b0;
  assign unused_bits   = ^{writedata, 32'(BLINK_FRAMES)};
`endif

  // Output decode uses the timer's look-ahead index so seg_n changes on the
  // same edge that dig_n drops the previous digit.
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  cur_dp;
  logic                  cur_blink;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] dig_d;

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    seg_d     = 8'hFF;
    dig_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_index == i[2:0]) begin
        cur_nib   = digits_q[4*i +: 4];
        cur_blank = blank_q[i];
        cur_dp    = dp_q[i];
        cur_blink = blink_q[i];
      end
    end
    if (enable_q) begin
      if (!(cur_blank || (cur_blink && blink_phase_d))) begin
        seg_d = ~{cur_dp, hex7(cur_nib)};
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_d[i] = !(slot_active && (scan_index == i[2:0]));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n <= 8'hFF;
      dig_n <= '1;
    end else begin
      seg_n <= seg_d;
      dig_n <= dig_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DIGITS: readdata[4*NUM_DIGITS-1:0] = digits_q;
      ADDR_CTRL: begin
        readdata[CTRL_ENABLE_BIT]             = enable_q;
        readdata[CTRL_BLANK_LSB +: NUM_DIGITS] = blank_q;
        readdata[CTRL_DP_LSB +: NUM_DIGITS]    = dp_q;
      end
      ADDR_BLINK: readdata[NUM_DIGITS-1:0] = blink_q;
      default: begin
        readdata[2:0]              = cur_index;
        readdata[STATUS_FRAME_BIT] = frame;
        readdata[STATUS_BLINK_BIT] = blink_phase_q;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl (adapts to SEG7_BLINK_EN)
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DT = 1;
  localparam int BF = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int n_checks = 0;
  int n_pass = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .DEADTIME    (DT),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .seg_n     (seg_n),
    .dig_n     (dig_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: elapsed enabled clocks t since scanning (re)started; everything
  // about the scan follows from t by division.
  int          t = 0;
  int          wraps = 0;
  int          m_idx;
  logic        m_phase = 1'b0;
  logic [15:0] m_digits = 16'd0;
  logic        m_en = 1'b1;
  logic [3:0]  m_blank = 4'd0;
  logic [3:0]  m_dp = 4'd0;
  logic [3:0]  m_blink = 4'd0;
  logic [7:0]  e_seg = 8'hFF;
  logic [3:0]  e_dig = 4'hF;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'((t / SD) % ND);
    s[8] = ((t / (SD * ND)) % 2) == 1;
    s[9] = m_phase;
    return s;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      t = 0; wraps = 0; m_phase = 1'b0;
      m_digits = 16'd0; m_en = 1'b1; m_blank = 4'd0; m_dp = 4'd0; m_blink = 4'd0;
      e_seg = 8'hFF; e_dig = 4'hF;
    end else begin
      if (m_en) begin
        t = t + 1;
        if (t % (SD * ND) == 0) wraps++;
      end else begin
        t = 0;
      end
`ifdef SEG7_BLINK_EN
      m_phase = ((wraps / BF) % 2) == 1;
`endif
      if (!m_en) begin
        e_seg = 8'hFF; e_dig = 4'hF;
      end else begin
        m_idx = (t / SD) % ND;
        e_dig = (t % SD >= DT) ? ~(4'b0001 << m_idx) : 4'hF;
        if (m_blank[m_idx] || (m_blink[m_idx] && m_phase)) e_seg = 8'hFF;
        else e_seg = ~{m_dp[m_idx], SEG_TAB[m_digits[4*m_idx +: 4]]};
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_digits = writedata[15:0];
          2'd1: begin m_en = writedata[0]; m_blank = writedata[11:8]; m_dp = writedata[19:16]; end
`ifdef SEG7_BLINK_EN
          2'd2: m_blink = writedata[3:0];
`endif
          default: ;
        endcase
      end
    end
    #1;
    check("model_seg_n", seg_n, e_seg);
    check("model_dig_n", dig_n, e_dig);
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic wait_dig(input logic [3:0] target);
    int k;
    k = 0;
    @(negedge clk);
    while (dig_n !== target && k < 64) begin
      @(negedge clk);
      k++;
    end
    check("wait_dig", dig_n, target);
  endtask

  logic [3:0] seq [8] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF};
  logic       ph0;
  int         k;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", seg_n, 8'hFF);
    check("rst_dig", dig_n, 4'hF);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_dig", dig_n, seq[i]);
      check("post_rst_seg", seg_n, 8'hC0);
    end
    repeat (12) @(negedge clk);

    wr(2'd0, 32'h0000F8A1);
    rd_check("rd_digits", 2'd0, 32'h0000F8A1);
    wait_dig(4'b1110); check("d0_seg", seg_n, 8'hF9);
    wait_dig(4'b1101); check("d1_seg", seg_n, 8'h88);
    wait_dig(4'b1011); check("d2_seg", seg_n, 8'h80);
    wait_dig(4'b0111); check("d3_seg", seg_n, 8'h8E);

    wr(2'd1, 32'h00020401);
    rd_check("rd_ctrl", 2'd1, 32'h00020401);
    wait_dig(4'b1110); check("m0_seg", seg_n, 8'hF9);
    wait_dig(4'b1101); check("m1_dp_seg", seg_n, 8'h08);
    wait_dig(4'b1011); check("m2_blank_seg", seg_n, 8'hFF);
    wait_dig(4'b0111); check("m3_seg", seg_n, 8'h8E);

    wait_dig(4'b1011);
    wr(2'd1, 32'h0);
    @(negedge clk);
    check("dis_seg", seg_n, 8'hFF);
    check("dis_dig", dig_n, 4'hF);
    @(negedge clk);
    address = 2'd3;
    #1;
    check("dis_status_idx", readdata[2:0], 3'd0);
    check("dis_status", readdata, exp_status());
    repeat (5) @(negedge clk);
    wr(2'd1, 32'h1);
    check("resume_dead", dig_n, 4'hF);
    @(negedge clk);
    check("resume_dig0", dig_n, 4'hE);
    check("resume_seg0", seg_n, 8'hF9);

    wr(2'd2, 32'h1);
`ifdef SEG7_BLINK_EN
    rd_check("rd_blink", 2'd2, 32'h1);
    @(negedge clk);
    address = 2'd3;
    #1;
    for (int rep = 0; rep < 2; rep++) begin
      ph0 = readdata[9];
      k = 0;
      while (readdata[9] == ph0 && k < 200) begin
        @(negedge clk); #1; k++;
      end
      if (rep == 1) check("blink_period", k, 32);
      wait_dig(4'b1110);
      check("blink_d0_seg", seg_n, m_phase ? 8'hFF : 8'hF9);
      address = 2'd3;
      #1;
    end
`else
    rd_check("rd_blink", 2'd2, 32'h0);
    repeat (70) @(negedge clk);
    address = 2'd3;
    #1;
    check("no_blink_phase", readdata[9], 1'b0);
`endif
    repeat (20) @(negedge clk);

    wait_dig(4'b1101);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_seg", seg_n, 8'hFF);
    check("async_rst_dig", dig_n, 4'hF);
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("rd_digits_rst", 2'd0, 32'h0);
    rd_check("rd_ctrl_rst", 2'd1, 32'h1);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
